// File: rtl/br_pred_if.sv
// Fetch-lookup / EXE-update bundle for the branch predictor.
// The master side is the pipeline; the slave side is br_pred.
interface br_pred_if #(
    parameter int unsigned PC_SZ = 32
) ();
    logic             lk_req;
    logic [PC_SZ-1:0] lk_pc;
    logic             pr_vld;
    logic             pr_taken;
    logic [PC_SZ-1:0] pr_pc;
    logic             up_vld;
    logic [PC_SZ-1:0] up_pc;
    logic [1:0]       up_kind;
    logic             up_taken;
    logic [PC_SZ-1:0] up_tgt;
    logic             up_call;
    logic [PC_SZ-1:0] up_ret_addr;

    modport master (
        output lk_req, lk_pc, up_vld, up_pc, up_kind, up_taken, up_tgt, up_call, up_ret_addr,
        input  pr_vld, pr_taken, pr_pc
    );

    modport slave (
        input  lk_req, lk_pc, up_vld, up_pc, up_kind, up_taken, up_tgt, up_call, up_ret_addr,
        output pr_vld, pr_taken, pr_pc
    );
endinterface

// File: rtl/br_pred.sv
// Direct-mapped BTB branch predictor with 2-bit counters and a registered 1-cycle prediction.
// Define BR_RAS_EN to add a return-address stack used for predicted returns (kind 2).
module br_pred #(
    parameter int unsigned PC_SZ     = 32,
    parameter int unsigned BTB_DEPTH = 64,
    parameter int unsigned PC_LSB    = 1,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic      clk_in,
    input  logic      reset_in,
    input  logic      flush_in,
    br_pred_if.slave  bus
);
    localparam int unsigned IW = $clog2(BTB_DEPTH);
    localparam int unsigned TW = PC_SZ - PC_LSB - IW;

    logic [BTB_DEPTH-1:0] valid_q, valid_d;
    logic [TW-1:0]        tag_q  [BTB_DEPTH];
    logic [PC_SZ-2:0]     tgt_q  [BTB_DEPTH];
    logic [1:0]           kind_q [BTB_DEPTH];
    logic [1:0]           ctr_q  [BTB_DEPTH];

    logic             pr_vld_q, pr_vld_d;
    logic             pr_taken_q, pr_taken_d;
    logic [PC_SZ-1:0] pr_pc_q, pr_pc_d;

    logic [IW-1:0]    lk_idx, up_idx;
    logic [TW-1:0]    lk_tag, up_tag;
    logic             lk_hit, lk_taken, up_en, up_hit;
    logic [PC_SZ-1:0] btb_tgt, pred_tgt;

    logic             ent_wr;
    logic [PC_SZ-2:0] ent_tgt_d;
    logic [1:0]       ent_ctr_d;

    assign lk_idx  = bus.lk_pc[PC_LSB +: IW];
    assign lk_tag  = bus.lk_pc[PC_SZ-1 -: TW];
    assign up_idx  = bus.up_pc[PC_LSB +: IW];
    assign up_tag  = bus.up_pc[PC_SZ-1 -: TW];

    // A lookup coinciding with a flush sees an empty table.
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !flush_in;
    assign lk_taken = lk_hit && ((kind_q[lk_idx] != 2'd0) || ctr_q[lk_idx][1]);
    assign btb_tgt  = {tgt_q[lk_idx], 1'b0};

    assign up_en  = bus.up_vld && !flush_in && (bus.up_kind != 2'd3);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

`ifdef BR_RAS_EN
    localparam int unsigned RW = $clog2(RAS_DEPTH);

    logic [PC_SZ-1:0] ras_q [RAS_DEPTH];
    logic [RW-1:0]    ras_ptr_q, ras_ptr_d, ras_wa;
    logic [RW:0]      ras_cnt_q, ras_cnt_d;
    logic             ras_we, ras_push, ras_pop;

    assign ras_push = up_en && bus.up_call;
    assign ras_pop  = up_en && (bus.up_kind == 2'd2);

    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_we    = 1'b0;
        ras_wa    = ras_ptr_q;
        if (flush_in) begin
            ras_ptr_d = '0;
            ras_cnt_d = '0;
        end else if (ras_push && ras_pop) begin
            ras_we = 1'b1;
        end else if (ras_push) begin
            // Pointer wraps, so a full stack overwrites its oldest entry.
            ras_ptr_d = ras_ptr_q + 1'b1;
            ras_wa    = ras_ptr_d;
            ras_we    = 1'b1;
            if (ras_cnt_q != (RW+1)'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + 1'b1;
        end else if (ras_pop && (ras_cnt_q != '0)) begin
            ras_ptr_d = ras_ptr_q - 1'b1;
            ras_cnt_d = ras_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (ras_we) ras_q[ras_wa] <= bus.up_ret_addr;
    end

    always_comb begin
        pred_tgt = btb_tgt;
        if ((kind_q[lk_idx] == 2'd2) && (ras_cnt_q != '0)) pred_tgt = ras_q[ras_ptr_q];
    end
`else
    logic unused_ras;
    assign unused_ras = ^{bus.up_call, bus.up_ret_addr};
    assign pred_tgt   = btb_tgt;
`endif

    logic unused_lsb;
    assign unused_lsb = ^{bus.up_tgt[0], bus.up_pc[PC_LSB-1:0]};

    always_comb begin
        pr_vld_d   = bus.lk_req && !flush_in;
        pr_taken_d = pr_taken_q;
        pr_pc_d    = pr_pc_q;
        if (bus.lk_req) begin
            pr_taken_d = lk_taken;
            pr_pc_d    = lk_taken ? pred_tgt : bus.lk_pc + PC_SZ'(4);
        end
    end

    always_comb begin
        ent_wr    = 1'b0;
        ent_tgt_d = tgt_q[up_idx];
        ent_ctr_d = ctr_q[up_idx];
        if (up_en) begin
            if (up_hit) begin
                ent_wr = 1'b1;
                if (bus.up_kind == 2'd0) begin
                    if (bus.up_taken) begin
                        ent_tgt_d = bus.up_tgt[PC_SZ-1:1];
                        if (ctr_q[up_idx] != 2'b11) ent_ctr_d = ctr_q[up_idx] + 2'd1;
                    end else if (ctr_q[up_idx] != 2'b00) begin
                        ent_ctr_d = ctr_q[up_idx] - 2'd1;
                    end
                end else begin
                    ent_tgt_d = bus.up_tgt[PC_SZ-1:1];
                    ent_ctr_d = 2'b11;
                end
            end else if (bus.up_taken) begin
                ent_wr    = 1'b1;
                ent_tgt_d = bus.up_tgt[PC_SZ-1:1];
                ent_ctr_d = (bus.up_kind == 2'd0) ? 2'b10 : 2'b11;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (flush_in) valid_d = '0;
        else if (ent_wr) valid_d[up_idx] = 1'b1;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            valid_q    <= '0;
            pr_vld_q   <= 1'b0;
            pr_taken_q <= 1'b0;
            pr_pc_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            pr_vld_q   <= pr_vld_d;
            pr_taken_q <= pr_taken_d;
            pr_pc_q    <= pr_pc_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (ent_wr) begin
            tag_q[up_idx]  <= up_tag;
            tgt_q[up_idx]  <= ent_tgt_d;
            kind_q[up_idx] <= bus.up_kind;
            ctr_q[up_idx]  <= ent_ctr_d;
        end
    end

    assign bus.pr_vld   = pr_vld_q;
    assign bus.pr_taken = pr_taken_q;
    assign bus.pr_pc    = pr_pc_q;
endmodule

// File: tb/tb_br_pred.sv
// Scoreboard bench for br_pred: a table-level model predicts every cycle's registered output.
// Define BR_RAS_EN to also exercise the return-address stack.
module tb_br_pred;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned RASD  = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    br_pred_if #(.PC_SZ(32)) bus ();

    br_pred #(.PC_SZ(32), .BTB_DEPTH(DEPTH), .PC_LSB(1), .RAS_DEPTH(RASD)) dut (
        .clk_in   (clk),
        .reset_in (rst_n),
        .flush_in (flush),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Model state: one record per BTB slot plus a queue for the return stack.
    bit          m_valid [DEPTH];
    logic [31:0] m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_kind  [DEPTH];
    int          m_ctr   [DEPTH];
    logic [31:0] m_ras   [$];
    bit          last_taken = 1'b0;
    logic [31:0] last_pc    = 32'h0;

    logic [33:0] exp_q [$];
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 1) % DEPTH);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc / (2 * DEPTH);
    endfunction

    task automatic model_update(bit uv, logic [31:0] upc, int uk, bit ut, logic [31:0] utg,
                                bit uc, logic [31:0] ura, bit fl);
        int  i;
        bit  hit;
        if (fl) begin
            for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
            m_ras.delete();
            return;
        end
        if (!uv || uk == 3) return;
        i   = idx_of(upc);
        hit = m_valid[i] && (m_tag[i] == tag_of(upc));
        if (hit) begin
            if (uk == 0) begin
                m_ctr[i] = ut ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                              : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (ut) m_tgt[i] = utg & ~32'h1;
            end else begin
                m_tgt[i] = utg & ~32'h1;
                m_ctr[i] = 3;
            end
            m_kind[i] = uk;
        end else if (ut) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(upc);
            m_tgt[i]   = utg & ~32'h1;
            m_kind[i]  = uk;
            m_ctr[i]   = (uk == 0) ? 2 : 3;
        end
`ifdef BR_RAS_EN
        if (uc && uk == 2) begin
            if (m_ras.size() > 0) m_ras[m_ras.size()-1] = ura;
        end else if (uc) begin
            m_ras.push_back(ura);
            if (m_ras.size() > RASD) void'(m_ras.pop_front());
        end else if (uk == 2 && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
`endif
    endtask

    task automatic step(bit lk, logic [31:0] lpc, bit uv, logic [31:0] upc, logic [1:0] uk,
                        bit ut, logic [31:0] utg, bit uc, logic [31:0] ura, bit fl);
        int  i;
        bit  hit;
        @(negedge clk);
        bus.lk_req = lk;       bus.lk_pc = lpc;
        bus.up_vld = uv;       bus.up_pc = upc;   bus.up_kind = uk;
        bus.up_taken = ut;     bus.up_tgt = utg;  bus.up_call = uc;  bus.up_ret_addr = ura;
        flush = fl;
        if (lk) begin
            i   = idx_of(lpc);
            hit = !fl && m_valid[i] && (m_tag[i] == tag_of(lpc));
            last_taken = hit && (m_kind[i] != 0 || m_ctr[i] >= 2);
            last_pc    = lpc + 32'd4;
            if (last_taken) begin
                last_pc = m_tgt[i];
`ifdef BR_RAS_EN
                if (m_kind[i] == 2 && m_ras.size() > 0) last_pc = m_ras[m_ras.size()-1];
`endif
            end
        end
        exp_q.push_back({lk && !fl, last_taken, last_pc});
        mon_en = 1'b1;
        model_update(uv, upc, int'(uk), ut, utg, uc, ura, fl);
    endtask

    task automatic lookup(logic [31:0] pc);
        step(1'b1, pc, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(logic [31:0] pc, logic [1:0] k, bit t, logic [31:0] tgt);
        step(1'b0, 32'h0, 1'b1, pc, k, t, tgt, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic call_upd(logic [31:0] pc, logic [31:0] ret);
        step(1'b0, 32'h0, 1'b1, pc, 2'd1, 1'b1, 32'h4000, 1'b1, ret, 1'b0);
    endtask

    always @(posedge clk) begin
        if (mon_en) begin
            logic [33:0] e;
            #1;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_underflow: output cycle with no expected entry");
            end else begin
                e = exp_q.pop_front();
                if ({bus.pr_vld, bus.pr_taken, bus.pr_pc} === e) n_pass++;
                else $display("FAIL pred @%0t: got vld=%0b taken=%0b pc=%h, want vld=%0b taken=%0b pc=%h",
                              $time, bus.pr_vld, bus.pr_taken, bus.pr_pc, e[33], e[32], e[31:0]);
            end
        end
    end

    initial begin
        bus.lk_req = 1'b0;  bus.lk_pc = '0;    bus.up_vld = 1'b0;  bus.up_pc = '0;
        bus.up_kind = '0;   bus.up_taken = 0;  bus.up_tgt = '0;    bus.up_call = 1'b0;
        bus.up_ret_addr = '0;
        flush = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            m_valid[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0; m_kind[k] = 0; m_ctr[k] = 0;
        end
        #12;
        n_checks++;
        if ({bus.pr_vld, bus.pr_taken, bus.pr_pc} === 34'h0) n_pass++;
        else $display("FAIL reset: got vld=%0b taken=%0b pc=%h, want all zero",
                      bus.pr_vld, bus.pr_taken, bus.pr_pc);
        rst_n = 1'b1;

        // Cold lookup, counter training and saturation.
        lookup(32'h100);
        upd(32'h100, 2'd0, 1'b1, 32'h80);
        lookup(32'h100);
        upd(32'h100, 2'd0, 1'b0, 32'h0);
        upd(32'h100, 2'd0, 1'b0, 32'h0);
        lookup(32'h100);
        for (int k = 0; k < 3; k++) upd(32'h100, 2'd0, 1'b1, 32'h80);
        lookup(32'h100);
        upd(32'h100, 2'd0, 1'b0, 32'h0);
        lookup(32'h100);

        // Aliasing: 0x180 evicts 0x100 from slot 0.
        upd(32'h180, 2'd1, 1'b1, 32'h501);
        lookup(32'h100);
        lookup(32'h180);

        // Read-before-write on the same slot.
        step(1'b1, 32'h200, 1'b1, 32'h200, 2'd1, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0);
        lookup(32'h200);

        // Flush beats a coincident update.
        upd(32'h300, 2'd1, 1'b1, 32'h700);
        lookup(32'h300);
        step(1'b0, 32'h0, 1'b1, 32'h300, 2'd1, 1'b1, 32'h700, 1'b0, 32'h0, 1'b1);
        lookup(32'h300);
        lookup(32'h180);
        lookup(32'h200);

        // Return target: stack top when available, BTB target otherwise.
        upd(32'h400, 2'd2, 1'b1, 32'h40);
        call_upd(32'h500, 32'h1004);
        call_upd(32'h500, 32'h2004);
        lookup(32'h400);
        upd(32'h400, 2'd2, 1'b1, 32'h40);
        lookup(32'h400);
        upd(32'h400, 2'd2, 1'b1, 32'h40);
        upd(32'h400, 2'd2, 1'b1, 32'h40);
        lookup(32'h400);
        for (int k = 0; k < 9; k++) call_upd(32'h500, 32'h3000 + 32'(k) * 4);
        for (int k = 0; k < 9; k++) begin
            lookup(32'h400);
            upd(32'h400, 2'd2, 1'b1, 32'h40);
        end
        lookup(32'h400);

        // Random traffic over a small PC pool so slots hit and alias often.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] lpc, upc;
            lpc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 1);
            upc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 1);
            step($urandom_range(0, 1) == 1, lpc, $urandom_range(0, 2) != 0, upc,
                 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, $urandom,
                 $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 63) == 0);
        end

        @(posedge clk);
        #3;
        mon_en = 1'b0;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
